ref_clk_edge_trainer: RTL and testbench
=======================================

Name: ref_clk_edge_trainer

Overview:
Fabric-side training controller for the DDR3 reference-clock capture IOD. It consumes the 8-bit deserialised CK samples (RX_DATA) and drives the IOD dynamic delay-line controls (LOAD/MOVE/DIRECTION) to sweep the receive delay. It locates the CK edge, then backs the delay line off by a fixed margin. The result (edge tap and final tap) is handed to the DDR PHY training sequencer.

Parameters:
MAX_TAPS, 128, number of delay taps swept before declaring failure
TAP_W, 7, width of tap counters (must satisfy 2^TAP_W >= MAX_TAPS)
SETTLE_CYCLES, 8, FAB_CLK cycles waited after any delay-line command before sampling
SAMPLE_COUNT, 16, consecutive RX_DATA words compared per tap
BACKOFF_TAPS, 4, taps moved back from the detected edge
PATTERN_A, 8'h55, legal CK sample word, phase A
PATTERN_B, 8'hAA, legal CK sample word, phase B (bitwise inverse of A)

Ports:
FAB_CLK  in  1  fabric clock; same clock as the IOD RX_CLK
RESET  in  1  asynchronous, active-high reset
TRAIN_START  in  1  level request; sampled only in IDLE, DONE and ERROR
RX_DATA  in  8  deserialised CK samples from the IOD
DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag
DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads the IOD delay line to its static value (tap 0)
DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap
DELAY_LINE_DIRECTION  out  1  1 = increase delay, 0 = decrease
EYE_MONITOR_CLEAR_FLAGS  out  1  pulses in the same cycle as every LOAD or MOVE
TRAIN_BUSY  out  1  high in every state except IDLE, DONE and ERROR
TRAIN_DONE  out  1  held high in DONE
TRAIN_ERR  out  1  held high in ERROR
EDGE_TAP  out  TAP_W  tap at which the edge was detected; valid when TRAIN_DONE=1
FINAL_TAP  out  TAP_W  current delay-line tap; tracks every MOVE

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters and ref_valid cleared. Reset asserted mid-sweep aborts immediately; no further pulses are issued. The IOD delay-line position after such an abort is undefined; the next run begins with LOAD.
- All outputs are registered.
- DIRECTION changes only in cycles where MOVE=0. It is set one cycle before the MOVE it qualifies and held through that MOVE.
- States and transitions:
  - IDLE: if TRAIN_START=1, go to LOAD.
  - LOAD: LOAD=1 and CLEAR=1 for one cycle; tap_cnt=0, FINAL_TAP=0, ref_valid=0. Go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: capture the first word w0. The tap is stable iff w0 is PATTERN_A or PATTERN_B and all SAMPLE_COUNT words equal w0. Takes exactly SAMPLE_COUNT cycles, then go to EVAL.
  - EVAL: exactly one cycle; evaluated in this priority order:
    - Unstable tap: go to MOVE_UP.
    - Stable and ref_valid=0: ref_word=w0, ref_valid=1, go to MOVE_UP.
    - Stable, ref_valid=1 and w0 != ref_word: EDGE_TAP=tap_cnt, go to BACKOFF.
    - Otherwise: go to MOVE_UP.
  - MOVE_UP:
    - If tap_cnt == MAX_TAPS-1, go to ERROR.
    - Otherwise DIRECTION=1, then a one-cycle MOVE+CLEAR pulse; tap_cnt++ and FINAL_TAP++. Go to SETTLE.
  - BACKOFF: backoff_cnt = min(BACKOFF_TAPS, EDGE_TAP). Issue backoff_cnt MOVE pulses with DIRECTION=0, spaced SETTLE_CYCLES apart; FINAL_TAP-- on each. Go to DONE. If backoff_cnt=0, go straight to DONE.
  - DONE / ERROR: hold the flag high. TRAIN_START=1 clears the flag and goes to LOAD in the next cycle.
- DELAY_LINE_OUT_OF_RANGE=1 in any busy state other than LOAD and the following SETTLE goes to ERROR next cycle, with no further pulses.
- TRAIN_START while busy is ignored.
- Counters never wrap: tap_cnt is bounded by MAX_TAPS-1, and FINAL_TAP never goes below 0.
- Sweep latency per tap = 1 (MOVE) + SETTLE_CYCLES + SAMPLE_COUNT + 1 (EVAL) cycles.

Test Plan:
- Model word 8'h55 for taps 0..19 and 8'hAA from tap 20; TRAIN_START=1 for 1 cycle -> 20 up-MOVEs, then 4 down-MOVEs; EDGE_TAP=20, FINAL_TAP=16, TRAIN_DONE=1; first LOAD issued 1 cycle after TRAIN_START.
- Edge at tap 2 -> only 2 down-MOVEs issued; FINAL_TAP=0; TRAIN_DONE=1.
- Taps 0..5 jitter between 8'h55 and 8'h54, 8'hAA from tap 6 onward, tap 30 = 8'h55 -> ref_word=8'hAA set at tap 6; EDGE_TAP=30, FINAL_TAP=26.
- Constant 8'h55 at every tap -> 127 MOVEs, then TRAIN_ERR=1 with no 128th MOVE; TRAIN_BUSY=0.
- OUT_OF_RANGE asserted at tap 10 -> TRAIN_ERR=1 within 1 cycle; no further MOVE pulses; FINAL_TAP=10.
- RESET pulsed during BACKOFF -> all outputs 0 asynchronously; a following TRAIN_START begins with a LOAD pulse; cycle-exact pulse spacing (SETTLE_CYCLES+SAMPLE_COUNT+2) is checked throughout.

Source files
------------

// File: rtl/ref_clk_edge_trainer.sv
// Reference-clock capture trainer: sweeps the IOD receive delay tap by tap, finds the CK edge
// from the deserialised sample words, then backs the delay line off by a fixed margin.
module ref_clk_edge_trainer #(
  parameter int unsigned MaxTaps      = 128,
  parameter int unsigned TapW         = 7,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned SampleCount  = 16,
  parameter int unsigned BackoffTaps  = 4,
  parameter logic [7:0]  PatternA     = 8'h55,
  parameter logic [7:0]  PatternB     = 8'hAA
) (
  input  logic            fab_clk_i,
  input  logic            reset_i,
  input  logic            train_start_i,
  input  logic [7:0]      rx_data_i,
  input  logic            delay_line_out_of_range_i,
  output logic            delay_line_load_o,
  output logic            delay_line_move_o,
  output logic            delay_line_direction_o,
  output logic            eye_monitor_clear_flags_o,
  output logic            train_busy_o,
  output logic            train_done_o,
  output logic            train_err_o,
  output logic [TapW-1:0] edge_tap_o,
  output logic [TapW-1:0] final_tap_o
);

  localparam int unsigned   CntW       = $clog2(SettleCycles + SampleCount + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleCount - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [TapW-1:0] TapLast    = TapW'(MaxTaps - 1);
  localparam logic [TapW-1:0] BackoffMax = TapW'(BackoffTaps);
  localparam logic [TapW-1:0] TapOne     = TapW'(1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StSettle, StSample, StEval, StMoveUp, StBackoff, StDone, StError
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [TapW-1:0] tap_cnt_q, final_tap_q, edge_tap_q, bo_rem_q;
  logic [7:0]      w0_q, ref_word_q;
  logic            stable_q, ref_valid_q, load_settle_q;
  logic            load_q, move_q, dir_q, clr_q, busy_q, done_q, err_q;

  logic            word_is_pattern;
  logic            oor_abort;
  logic            edge_found;
  logic [TapW-1:0] backoff_init;

  always_comb begin
    word_is_pattern = (rx_data_i == PatternA) || (rx_data_i == PatternB);
    // The limit flag is meaningless while the line reloads and settles after LOAD.
    oor_abort = delay_line_out_of_range_i && busy_q && (state_q != StLoad) &&
                !((state_q == StSettle) && load_settle_q);
    edge_found   = stable_q && ref_valid_q && (w0_q != ref_word_q);
    backoff_init = (tap_cnt_q < BackoffMax) ? tap_cnt_q : BackoffMax;
  end

  always_ff @(posedge fab_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      tap_cnt_q     <= '0;
      final_tap_q   <= '0;
      edge_tap_q    <= '0;
      bo_rem_q      <= '0;
      w0_q          <= '0;
      ref_word_q    <= '0;
      stable_q      <= 1'b0;
      ref_valid_q   <= 1'b0;
      load_settle_q <= 1'b0;
      load_q        <= 1'b0;
      move_q        <= 1'b0;
      dir_q         <= 1'b0;
      clr_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      load_q <= 1'b0;
      move_q <= 1'b0;
      clr_q  <= 1'b0;
      if (oor_abort) begin
        state_q <= StError;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StDone, StError: begin
            if (train_start_i) begin
              state_q       <= StLoad;
              load_q        <= 1'b1;
              clr_q         <= 1'b1;
              dir_q         <= 1'b1;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
              err_q         <= 1'b0;
              tap_cnt_q     <= '0;
              final_tap_q   <= '0;
              edge_tap_q    <= '0;
              ref_valid_q   <= 1'b0;
              load_settle_q <= 1'b0;
            end
          end
          StLoad: begin
            state_q       <= StSettle;
            cnt_q         <= '0;
            load_settle_q <= 1'b1;
          end
          StSettle: begin
            if (cnt_q == SettleLast) begin
              state_q       <= StSample;
              cnt_q         <= '0;
              load_settle_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StSample: begin
            if (cnt_q == '0) begin
              w0_q     <= rx_data_i;
              stable_q <= word_is_pattern;
            end else if (rx_data_i != w0_q) begin
              stable_q <= 1'b0;
            end
            if (cnt_q == SampleLast) begin
              state_q <= StEval;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StEval: begin
            if (edge_found) begin
              edge_tap_q <= tap_cnt_q;
              bo_rem_q   <= backoff_init;
              cnt_q      <= '0;
              if (backoff_init == '0) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= StBackoff;
                dir_q   <= 1'b0;
              end
            end else if (tap_cnt_q == TapLast) begin
              state_q <= StError;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              if (stable_q && !ref_valid_q) begin
                ref_word_q  <= w0_q;
                ref_valid_q <= 1'b1;
              end
              // Direction has been high since LOAD, so the up-move is already qualified.
              state_q     <= StMoveUp;
              move_q      <= 1'b1;
              clr_q       <= 1'b1;
              tap_cnt_q   <= tap_cnt_q + TapOne;
              final_tap_q <= final_tap_q + TapOne;
            end
          end
          StMoveUp: begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
          StBackoff: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CntOne;
            end else if (bo_rem_q == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              move_q      <= 1'b1;
              clr_q       <= 1'b1;
              final_tap_q <= final_tap_q - TapOne;
              bo_rem_q    <= bo_rem_q - TapOne;
              cnt_q       <= SettleLast;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign delay_line_load_o         = load_q;
  assign delay_line_move_o         = move_q;
  assign delay_line_direction_o    = dir_q;
  assign eye_monitor_clear_flags_o = clr_q;
  assign train_busy_o              = busy_q;
  assign train_done_o              = done_q;
  assign train_err_o               = err_q;
  assign edge_tap_o                = edge_tap_q;
  assign final_tap_o               = final_tap_q;

endmodule

// File: tb/tb_ref_clk_edge_trainer.sv
// Bench for ref_clk_edge_trainer: an IOD model serves per-tap sample words and a tap-level
// reference model predicts edge, final tap, move counts and pulse spacing.
module tb_ref_clk_edge_trainer;

  localparam int MaxTaps      = 128;
  localparam int SettleCycles = 8;
  localparam int SampleCount  = 16;
  localparam int BackoffTaps  = 4;
  localparam int TapPeriod    = SettleCycles + SampleCount + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       oor = 1'b0;
  logic [7:0] rx = 8'h00;
  logic       load, move, dir, clr, busy, done, err;
  logic [6:0] edge_tap, final_tap;

  ref_clk_edge_trainer dut (
    .fab_clk_i                 (clk),
    .reset_i                   (rst),
    .train_start_i             (start),
    .rx_data_i                 (rx),
    .delay_line_out_of_range_i (oor),
    .delay_line_load_o         (load),
    .delay_line_move_o         (move),
    .delay_line_direction_o    (dir),
    .eye_monitor_clear_flags_o (clr),
    .train_busy_o              (busy),
    .train_done_o              (done),
    .train_err_o               (err),
    .edge_tap_o                (edge_tap),
    .final_tap_o               (final_tap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-tap word table: jittering taps alternate 55/54 every cycle.
  bit         jit [MaxTaps];
  logic [7:0] tw  [MaxTaps];
  int         iod_tap = 0;
  int         cyc = 0;
  int         n_up, n_down, n_loads;
  int         last_pulse, last_up, last_down;
  logic       dir_prev = 1'b0;

  initial begin
    n_up = 0; n_down = 0; n_loads = 0;
    last_pulse = 0; last_up = 0; last_down = 0;
  end

  // Monitor: IOD tap tracking and cycle-exact pulse spacing.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (load) begin
        iod_tap = 0;
        n_loads++;
        last_pulse = cyc;
      end
      if (move) begin
        check_eq("dir_setup", dir, dir_prev);
        if (dir) begin
          n_up++;
          iod_tap++;
          check_eq("up_spacing", cyc - last_pulse, TapPeriod);
          last_pulse = cyc;
          last_up    = cyc;
        end else begin
          n_down++;
          iod_tap--;
          if (n_down == 1) check_eq("first_down_spacing", cyc - last_up, TapPeriod + 1);
          else check_eq("down_spacing", cyc - last_down, SettleCycles);
          last_down = cyc;
        end
        check_eq("final_track", final_tap, iod_tap);
      end
      if (load || move || clr) check_eq("clear_pulse", clr, load | move);
    end
    dir_prev = dir;
  end

  // IOD sample driver.
  initial forever begin
    @(posedge clk);
    #2;
    if (iod_tap < 0 || iod_tap >= MaxTaps) rx = 8'h00;
    else if (jit[iod_tap]) rx = cyc[0] ? 8'h55 : 8'h54;
    else rx = tw[iod_tap];
  end

  function automatic void model(output bit m_err, output int m_edge, output int m_ups,
                                output int m_downs, output int m_final);
    bit         rv;
    bit         st;
    logic [7:0] rw;
    rv = 1'b0; rw = 8'h00;
    m_err = 1'b0; m_edge = 0; m_ups = 0; m_downs = 0; m_final = 0;
    for (int t = 0; t < MaxTaps; t++) begin
      st = !jit[t] && (tw[t] == 8'h55 || tw[t] == 8'hAA);
      if (st && rv && tw[t] != rw) begin
        m_edge  = t;
        m_ups   = t;
        m_downs = (t < BackoffTaps) ? t : BackoffTaps;
        m_final = t - m_downs;
        return;
      end
      if (st && !rv) begin
        rv = 1'b1;
        rw = tw[t];
      end
    end
    m_err   = 1'b1;
    m_ups   = MaxTaps - 1;
    m_final = MaxTaps - 1;
  endfunction

  task automatic set_simple(input int edge_t, input logic [7:0] a, input logic [7:0] b);
    for (int t = 0; t < MaxTaps; t++) begin
      jit[t] = 1'b0;
      tw[t]  = (t < edge_t) ? a : b;
    end
  endtask

  task automatic pulse_start(input string name);
    @(negedge clk);
    n_up = 0; n_down = 0; n_loads = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, ":first_load"}, load, 1);
    check_eq({name, ":flags_cleared"}, {done, err}, 0);
  endtask

  task automatic run_and_check(input string name, input bit poke_busy);
    bit m_err;
    int m_edge, m_ups, m_downs, m_final;
    model(m_err, m_edge, m_ups, m_downs, m_final);
    pulse_start(name);
    if (poke_busy) begin
      for (int i = 0; i < 200; i++) begin
        if (n_up >= 1) break;
        @(negedge clk);
      end
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 6000; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    check_eq({name, ":finished"}, done | err, 1);
    repeat (30) @(negedge clk);
    check_eq({name, ":done"}, done, !m_err);
    check_eq({name, ":err"}, err, m_err);
    check_eq({name, ":busy"}, busy, 0);
    if (!m_err) check_eq({name, ":edge_tap"}, edge_tap, m_edge);
    check_eq({name, ":final_tap"}, final_tap, m_final);
    check_eq({name, ":up_moves"}, n_up, m_ups);
    check_eq({name, ":down_moves"}, n_down, m_downs);
    check_eq({name, ":loads"}, n_loads, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_simple(MaxTaps, 8'h55, 8'h55);
    #1;
    check_eq("reset_outputs", {load, move, dir, clr, busy, done, err, edge_tap, final_tap}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_outputs", {load, move, dir, clr, busy, done, err, edge_tap, final_tap}, 0);

    set_simple(20, 8'h55, 8'hAA);
    run_and_check("edge20", 1'b0);

    set_simple(2, 8'h55, 8'hAA);
    run_and_check("edge2", 1'b0);

    for (int t = 0; t < MaxTaps; t++) begin
      jit[t] = (t < 6);
      tw[t]  = (t >= 6 && t != 30) ? 8'hAA : 8'h55;
    end
    run_and_check("jitter_edge30", 1'b0);

    set_simple(MaxTaps, 8'h55, 8'h55);
    run_and_check("no_edge", 1'b0);

    // Limit flag ignored during LOAD and its settle, honoured later in the sweep.
    set_simple(MaxTaps, 8'h55, 8'h55);
    pulse_start("oor");
    oor = 1'b1;
    repeat (SettleCycles) @(negedge clk);
    oor = 1'b0;
    check_eq("oor:ignored_after_load", {busy, err}, 2'b10);
    for (int i = 0; i < 600; i++) begin
      if (n_up >= 10) break;
      @(negedge clk);
    end
    check_eq("oor:reached_tap10", n_up, 10);
    repeat (3) @(negedge clk);
    oor = 1'b1;
    @(negedge clk);
    check_eq("oor:err", err, 1);
    check_eq("oor:busy", busy, 0);
    repeat (60) @(negedge clk);
    oor = 1'b0;
    check_eq("oor:no_more_moves", n_up + n_down, 10);
    check_eq("oor:final_tap", final_tap, 10);
    check_eq("oor:err_held", err, 1);

    // Asynchronous reset in the middle of the backoff.
    set_simple(20, 8'h55, 8'hAA);
    pulse_start("abort");
    for (int i = 0; i < 2000; i++) begin
      if (n_down >= 1) break;
      @(negedge clk);
    end
    check_eq("abort:in_backoff", n_down, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort:outputs_zero",
             {load, move, dir, clr, busy, done, err, edge_tap, final_tap}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort:quiet", n_down, 1);
    set_simple(2, 8'hAA, 8'h55);
    run_and_check("after_abort", 1'b0);

    // Randomised tap tables: unstable prefix, occasional unstable taps, random polarity.
    for (int trial = 0; trial < 5; trial++) begin
      int         p, e;
      logic [7:0] a;
      p = $urandom_range(0, 8);
      e = p + $urandom_range(2, 30);
      a = $urandom_range(0, 1) ? 8'h55 : 8'hAA;
      for (int t = 0; t < MaxTaps; t++) begin
        jit[t] = 1'b0;
        if (t < p) begin
          jit[t] = $urandom_range(0, 1);
          tw[t]  = 8'h0F;
        end else if (t < e) begin
          jit[t] = (t > p) && ($urandom_range(0, 5) == 0);
          tw[t]  = a;
        end else begin
          tw[t] = ~a;
        end
      end
      run_and_check($sformatf("rand%0d", trial), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
